mem_access_seq: RTL and testbench

//  Multicycle memory-access sequencer between the main control FSM and the word-wide data memory.

---
 rtl/mem_seq_pkg.sv | 38 +++
 rtl/byte_lane_unit.sv | 57 +++++
 rtl/mem_access_seq.sv | 126 ++++++++++++
 tb/tb_mem_access_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory-access sequencer: op and state encodings,
// plus the store/alignment classification used at request accept.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    function automatic logic is_store(input op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_aligned(input op_e op, input logic [1:0] lsb);
        logic ok;
        case (op)
            OP_LH, OP_LHU, OP_SH: ok = ~lsb[0];
            OP_LW, OP_SW:         ok = (lsb == 2'b00);
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane logic: extract/extend a load from the memory word and
// merge sub-word store data into the old word for read-modify-write.
module byte_lane_unit
    import mem_seq_pkg::*;
(
    input  op_e         i_op,
    input  logic [1:0]  i_lsb,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_lsb)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_lsb[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        case (i_op)
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'd0, w_byte};
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'd0, w_half};
            default: o_load = i_word;
        endcase
    end

    always_comb begin
        o_store = i_word;
        case (i_op)
            OP_SB: begin
                case (i_lsb)
                    2'd0:    o_store[7:0]   = i_wdata[7:0];
                    2'd1:    o_store[15:8]  = i_wdata[7:0];
                    2'd2:    o_store[23:16] = i_wdata[7:0];
                    default: o_store[31:24] = i_wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (i_lsb[1]) o_store[31:16] = i_wdata[15:0];
                else          o_store[15:0]  = i_wdata[15:0];
            end
            OP_SW:   o_store = i_wdata;
            default: o_store = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Single-request load/store sequencer in front of a word-wide memory with
// MEM_LAT read latency; sub-word stores are done as read-modify-write.
//
// state | meaning
// IDLE  | waiting for req; request fields latched on accept
// RD    | address driven, counting down MEM_LAT; word captured at cnt=0
// WR    | single mem_we cycle (SW data or merged sub-word word)
// DONE  | done pulse, load result visible on rdata
// ERR   | done pulse with align_err, memory untouched
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    input  logic [2:0]    i_op,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic          o_busy,
    output logic          o_done,
    output logic [31:0]   o_rdata,
    output logic          o_align_err,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic          o_mem_we,
    input  logic [31:0]   i_mem_rdata
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    state_e          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    op_e             r_op;
    logic [1:0]      r_lsb;
    logic [31:0]     r_wdata;
    logic            r_busy, r_done, r_align_err, r_mem_we;
    logic [31:0]     r_rdata, r_mem_wdata;
    logic [AW-1:0]   r_mem_addr;

    op_e             w_in_op;
    logic            w_accept, w_capture;
    logic [31:0]     w_load, w_store;

    assign w_in_op   = op_e'(i_op);
    assign w_accept  = (r_state == ST_IDLE) && i_req;
    assign w_capture = (r_state == ST_RD) && (r_cnt == '0);

    byte_lane_unit u_lane (
        .i_op    (r_op),
        .i_lsb   (r_lsb),
        .i_word  (i_mem_rdata),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_store (w_store)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    if (!is_aligned(w_in_op, i_addr[1:0])) w_state_nxt = ST_ERR;
                    else if (w_in_op == OP_SW)            w_state_nxt = ST_WR;
                    else                                  w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                if (r_cnt == '0) w_state_nxt = is_store(r_op) ? ST_WR : ST_DONE;
            end
            ST_WR:   w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= OP_LB;
            r_lsb       <= 2'b00;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_DONE) || (w_state_nxt == ST_ERR);
            r_align_err <= (w_state_nxt == ST_ERR);
            r_mem_we    <= (w_state_nxt == ST_WR);
            if (w_accept) begin
                r_op       <= w_in_op;
                r_lsb      <= i_addr[1:0];
                r_wdata    <= i_wdata;
                r_mem_addr <= {i_addr[AW-1:2], 2'b00};
                r_cnt      <= CW'(MEM_LAT - 1);
                if (w_in_op == OP_SW) r_mem_wdata <= i_wdata;
            end else if ((r_state == ST_RD) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                if (is_store(r_op)) r_mem_wdata <= w_store;
                else                r_rdata     <= w_load;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_align_err = r_align_err;
    assign o_mem_we    = r_mem_we;
    assign o_rdata     = r_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq with a small word memory behind it.
module tb_mem_access_seq;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req = 1'b0;
    logic [2:0]  i_op = 3'b000;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        o_busy, o_done, o_align_err, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;

    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    int          we_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    mem_access_seq #(.MEM_LAT(2), .AW(32)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_op        (i_op),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_align_err (o_align_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_we    (o_mem_we),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    assign i_mem_rdata = mem[o_mem_addr[7:2]];

    always @(posedge i_clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (o_mem_we) mem[o_mem_addr[7:2]] <= o_mem_wdata;
        if (o_mem_we) we_cnt = we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pl_idx = idx; pl_data = data; pl_en = 1'b1;
        @(posedge i_clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one request, scramble inputs after accept, return cycles to done.
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output int lat);
        i_op = op; i_addr = a; i_wdata = wd; i_req = 1'b1;
        @(posedge i_clk); #1;
        i_req = 1'b0; i_op = 3'b010; i_addr = 32'hFFFF_FFF0; i_wdata = 32'h5A5A_5A5A;
        lat = 1;
        chk("busy_after_accept", {31'd0, o_busy}, 32'd1);
        while (!o_done && lat < 20) begin
            @(posedge i_clk); #1;
            lat++;
        end
        @(posedge i_clk); #1;
        chk("idle_after_done", {30'd0, o_busy, o_done}, 32'd0);
    endtask

    initial begin
        int lat;
        int we0;
        int ndone;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_flags", {28'd0, o_busy, o_done, o_align_err, o_mem_we}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        i_rst = 1'b0;

        preload(6'd4, 32'hDEADBEEF);
        we0 = we_cnt;
        run(3'b010, 32'h10, 32'h0, lat);
        chk("lw_lat", lat, 32'd3);
        chk("lw_rdata", o_rdata, 32'hDEADBEEF);
        chk("lw_no_we", we_cnt - we0, 32'd0);
        chk("lw_mem_addr", o_mem_addr, 32'h10);

        preload(6'd4, 32'h80FF7F01);
        run(3'b000, 32'h13, 32'h0, lat);
        chk("lb_rdata", o_rdata, 32'hFFFFFF80);
        run(3'b011, 32'h13, 32'h0, lat);
        chk("lbu_rdata", o_rdata, 32'h00000080);
        run(3'b001, 32'h12, 32'h0, lat);
        chk("lh_rdata", o_rdata, 32'hFFFF80FF);
        run(3'b100, 32'h10, 32'h0, lat);
        chk("lhu_rdata", o_rdata, 32'h00007F01);
        chk("lhu_lat", lat, 32'd3);

        preload(6'd8, 32'h11223344);
        we0 = we_cnt;
        run(3'b101, 32'h21, 32'h000000AA, lat);
        chk("sb_lat", lat, 32'd4);
        chk("sb_we_pulses", we_cnt - we0, 32'd1);
        chk("sb_mem", mem[8], 32'h1122AA44);
        chk("sb_rdata_held", o_rdata, 32'h00007F01);

        preload(6'd12, 32'h55667788);
        run(3'b110, 32'h32, 32'h1234CAFE, lat);
        chk("sh_lat", lat, 32'd4);
        chk("sh_mem", mem[12], 32'hCAFE7788);

        we0 = we_cnt;
        run(3'b111, 32'h24, 32'h0BADF00D, lat);
        chk("sw_lat", lat, 32'd2);
        chk("sw_mem", mem[9], 32'h0BADF00D);
        chk("sw_we_pulses", we_cnt - we0, 32'd1);

        we0 = we_cnt;
        i_op = 3'b111; i_addr = 32'h22; i_wdata = 32'hFFFFFFFF; i_req = 1'b1;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        chk("sw_mis_done_c1", {30'd0, o_done, o_align_err}, 32'd3);
        chk("sw_mis_we", {31'd0, o_mem_we}, 32'd0);
        chk("sw_mis_rdata", o_rdata, 32'h00007F01);
        @(posedge i_clk); #1;
        chk("sw_mis_after", {29'd0, o_busy, o_done, o_align_err}, 32'd0);
        chk("sw_mis_no_we", we_cnt - we0, 32'd0);
        chk("sw_mis_mem", mem[8], 32'h1122AA44);

        run(3'b001, 32'h03, 32'h0, lat);
        chk("lh_mis_lat", lat, 32'd1);
        chk("lh_mis_err", {31'd0, o_align_err}, 32'd0);
        i_op = 3'b001; i_addr = 32'h03; i_req = 1'b1;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        chk("lh_mis_flag", {30'd0, o_done, o_align_err}, 32'd3);
        @(posedge i_clk); #1;

        // Reset in the last RD cycle of an SH: the WR that would follow is dropped.
        we0 = we_cnt;
        i_op = 3'b110; i_addr = 32'h30; i_wdata = 32'h0000BEEF; i_req = 1'b1;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("rst_mid_flags", {29'd0, o_busy, o_done, o_mem_we}, 32'd0);
        @(posedge i_clk); #1;
        chk("rst_mid_no_we", we_cnt - we0, 32'd0);
        chk("rst_mid_mem", mem[12], 32'hCAFE7788);
        run(3'b010, 32'h30, 32'h0, lat);
        chk("post_rst_lw_lat", lat, 32'd3);
        chk("post_rst_lw", o_rdata, 32'hCAFE7788);

        // req held high: DONE cycle ignores it, next accept one cycle later.
        ndone = 0;
        i_op = 3'b010; i_addr = 32'h24; i_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge i_clk); #1;
            if (o_done) ndone++;
            if (c == 3) chk("b2b_done1", {31'd0, o_done}, 32'd1);
            if (c == 4) chk("b2b_idle", {31'd0, o_busy}, 32'd0);
            if (c == 5) chk("b2b_busy2", {31'd0, o_busy}, 32'd1);
            if (c == 7) chk("b2b_done2", {31'd0, o_done}, 32'd1);
        end
        i_req = 1'b0;
        chk("b2b_ndone", ndone, 32'd2);
        chk("b2b_rdata", o_rdata, 32'h0BADF00D);
        repeat (4) @(posedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
